secded_batch_sequencer: RTL

Hardware sequencer for the program-2 Hamming SECDED decode pass. On `req` it walks `COUNT` 16-bit codewords stored as byte pairs in data memory starting at `SRC_BASE`. It decodes and corrects each codeword and writes the 11-bit result plus error flags as byte pairs starting at `DST_BASE`. It then raises `ack`. It sits between the top level's `req`/`ack` handshake and the single-port byte-wide data memory, and drives that memory exclusively while busy.

---
 rtl/secded_pkg.sv | 33 +++
 rtl/secded_decode.sv | 33 +++
 rtl/secded_batch_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/secded_pkg.sv
// Shared definitions for the Hamming SECDED decode pass: FSM states,
// decode flag encodings and codeword bit positions.
package secded_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_CAP,
    ST_WR_HI,
    ST_WR_LO,
    ST_DONE
  } state_e;

  localparam logic [1:0] FLG_NONE = 2'b00;
  localparam logic [1:0] FLG_SGL  = 2'b01;
  localparam logic [1:0] FLG_DBL  = 2'b10;

  // Codeword layout MSB->LSB: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}
  localparam int unsigned CW_P0  = 0;
  localparam int unsigned CW_P1  = 1;
  localparam int unsigned CW_P2  = 2;
  localparam int unsigned CW_D1  = 3;
  localparam int unsigned CW_P4  = 4;
  localparam int unsigned CW_D2  = 5;
  localparam int unsigned CW_D4  = 7;
  localparam int unsigned CW_P8  = 8;
  localparam int unsigned CW_D5  = 9;
  localparam int unsigned CW_D11 = 15;

  localparam logic [6:0] CNT_MAX = 7'd127;

endpackage

// File: rtl/secded_decode.sv
// Combinational SECDED decoder: 16-bit codeword in, corrected 11-bit data
// and error flags out.
module secded_decode
  import secded_pkg::*;
(
  input  logic [15:0] codeword,
  output logic [10:0] data,
  output logic [1:0]  flags
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;

  always_comb begin
    syn = '0;
    for (int unsigned k = 1; k < 16; k++) begin
      if (codeword[k]) syn ^= 4'(k);
    end
    par   = ^codeword;
    fixed = codeword;
    flags = FLG_NONE;
    if (par) begin
      // Syndrome 0 with odd parity points at p0, so data is left untouched.
      flags      = FLG_SGL;
      fixed[syn] = ~codeword[syn];
    end else if (syn != 4'd0) begin
      flags = FLG_DBL;
    end
    data = {fixed[CW_D11:CW_D5], fixed[CW_D4:CW_D2], fixed[CW_D1]};
  end

endmodule

// File: rtl/secded_batch_sequencer.sv
// Walks COUNT codewords in byte-wide memory, decodes each through
// secded_decode and writes result words back, then raises ack.
module secded_batch_sequencer
  import secded_pkg::*;
#(
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int COUNT    = 15,
  parameter int AW       = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  output logic          ack,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [6:0]    single_cnt,
  output logic [6:0]    double_cnt
);

  state_e        state;
  logic [6:0]    idx;
  logic [15:0]   cw_q;
  logic [10:0]   dec_data;
  logic [1:0]    dec_flags;
  logic [15:0]   result;
  logic [AW-1:0] pair_off;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic          last_word;

  secded_decode u_decode (
    .codeword (cw_q),
    .data     (dec_data),
    .flags    (dec_flags)
  );

  assign result    = {dec_flags, 3'b000, dec_data};
  assign pair_off  = AW'({idx, 1'b0});
  assign src_addr  = AW'(SRC_BASE) + pair_off;
  assign dst_addr  = AW'(DST_BASE) + pair_off;
  assign last_word = (idx == 7'(COUNT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cw_q       <= '0;
      single_cnt <= '0;
      double_cnt <= '0;
      ack        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // ack/busy are registered from the current state, so they trail the FSM by one cycle.
      ack  <= (state == ST_DONE);
      busy <= (state inside {ST_RD_LO, ST_RD_HI, ST_CAP, ST_WR_HI, ST_WR_LO});
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (req) begin
            idx        <= '0;
            single_cnt <= '0;
            double_cnt <= '0;
            state      <= ST_RD_LO;
          end
        end
        ST_RD_LO: state <= ST_RD_HI;
        ST_RD_HI: begin
          cw_q[7:0] <= mem_rdata;
          state     <= ST_CAP;
        end
        ST_CAP: begin
          cw_q[15:8] <= mem_rdata;
          state      <= ST_WR_HI;
        end
        ST_WR_HI: begin
          if (dec_flags == FLG_SGL && single_cnt != CNT_MAX)
            single_cnt <= single_cnt + 7'd1;
          else if (dec_flags == FLG_DBL && double_cnt != CNT_MAX)
            double_cnt <= double_cnt + 7'd1;
          state <= ST_WR_LO;
        end
        ST_WR_LO: begin
          if (last_word) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 7'd1;
            state <= ST_RD_LO;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    unique case (state)
      ST_RD_LO: mem_addr = src_addr;
      ST_RD_HI: mem_addr = src_addr + AW'(1);
      ST_WR_HI: begin
        mem_addr  = dst_addr + AW'(1);
        mem_wr_en = 1'b1;
        mem_wdata = result[15:8];
      end
      ST_WR_LO: begin
        mem_addr  = dst_addr;
        mem_wr_en = 1'b1;
        mem_wdata = result[7:0];
      end
      default: ;
    endcase
  end

endmodule
